spi_slave_mode: RTL and testbench

//  Parametrised SPI slave, successor to spi_slave: all four SPI modes (runtime CPOL/CPHA), generic address/data widths.

---
 rtl/spi_slave_mode.sv | 165 ++++++++++++++++
 tb/tb_spi_slave_mode.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mode.sv
// spi_slave_mode: SPI slave supporting all four SPI modes, MSB-first frame of an address (MSB = R/W) then a data word.
// Ports: clk/rst_n (async active-low reset); CPOL/CPHA mode, latched while idle; spi_cs/spi_sck/spi_mosi in, spi_miso out;
//   txdata in (valid the cycle after txreq), txreq pulse; addr + addr_valid; rxdata + rx_valid; spi_over / frame_err at cs release.
// Config: define SPI_SLAVE_BURST_EN for multi-word frames with auto-incrementing address.
module spi_slave_mode #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic                  spi_cs,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic [DATA_WIDTH-1:0] txdata,
  output logic                  txreq,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_valid,
  output logic [DATA_WIDTH-1:0] rxdata,
  output logic                  rx_valid,
  output logic                  spi_over,
  output logic                  frame_err
);
  localparam int CW = $clog2(DATA_WIDTH + ADDR_WIDTH);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] cs_sy, sck_sy, mosi_sy;
  logic cs_s, sck_s, mosi_s, cs_d, sck_d;
  logic cpol_q, cpha_q;
  logic cs_fall, cs_rise, sck_rise, sck_fall, lead, trail, samp, shft;
  logic addr_last, word_last, boundary, over, err, rw, drv, ld;
  logic [CW-1:0] cnt;
  logic [ADDR_WIDTH-2:0] a_sr;
  logic [DATA_WIDTH-2:0] d_sr;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [ADDR_WIDTH-1:0] a_nx;
  logic [DATA_WIDTH-1:0] d_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cs_sy   <= '0;
      sck_sy  <= '0;
      mosi_sy <= '0;
      cs_d    <= 1'b0;
      sck_d   <= 1'b0;
    end else begin
      cs_sy   <= {cs_sy[SYNC_STAGES-2:0], spi_cs};
      sck_sy  <= {sck_sy[SYNC_STAGES-2:0], spi_sck};
      mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], spi_mosi};
      cs_d    <= cs_s;
      sck_d   <= sck_s;
    end
  assign cs_s      = cs_sy[SYNC_STAGES-1];
  assign sck_s     = sck_sy[SYNC_STAGES-1];
  assign mosi_s    = mosi_sy[SYNC_STAGES-1];
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sck_rise  = sck_s & ~sck_d;
  assign sck_fall  = ~sck_s & sck_d;
  assign lead      = cpol_q ? sck_fall : sck_rise;
  assign trail     = cpol_q ? sck_rise : sck_fall;
  assign samp      = cpha_q ? trail : lead;
  assign shft      = cpha_q ? lead : trail;
  assign rw        = addr[ADDR_WIDTH-1];
  assign a_nx      = {a_sr, mosi_s};
  assign d_nx      = {d_sr, mosi_s};
  assign addr_last = state == ADDR && samp && !cs_rise && cnt == CW'(ADDR_WIDTH-1);
  assign word_last = state == DATA && samp && !cs_rise && cnt == CW'(DATA_WIDTH-1);
  // Raw cs gates miso so it drops as soon as the master releases the bus, not after sync delay.
  assign spi_miso  = !spi_cs && state == DATA && drv && tx_sr[DATA_WIDTH-1];
`ifdef SPI_SLAVE_BURST_EN
  logic any_word;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) any_word <= 1'b0;
    else any_word <= state == IDLE ? 1'b0 : any_word | word_last;
  assign boundary = any_word && cnt == '0;
`else
  assign boundary = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    over     = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE: state_nx = cs_fall ? ADDR : IDLE;
      ADDR: begin
        err      = cs_rise;
        state_nx = cs_rise ? IDLE : addr_last ? DATA : ADDR;
      end
      DATA: begin
        over     = cs_rise && boundary;
        err      = cs_rise && !boundary;
`ifdef SPI_SLAVE_BURST_EN
        state_nx = cs_rise ? IDLE : DATA;
`else
        state_nx = cs_rise ? IDLE : word_last ? DONE : DATA;
`endif
      end
      default: begin
        over     = cs_rise;
        state_nx = cs_rise ? IDLE : DONE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      cnt        <= '0;
      a_sr       <= '0;
      d_sr       <= '0;
      tx_sr      <= '0;
      drv        <= 1'b0;
      ld         <= 1'b0;
      addr       <= '0;
      addr_valid <= 1'b0;
      txreq      <= 1'b0;
      rxdata     <= '0;
      rx_valid   <= 1'b0;
      spi_over   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      addr_valid <= 1'b0;
      txreq      <= 1'b0;
      rx_valid   <= 1'b0;
      spi_over   <= over;
      frame_err  <= err;
      ld         <= txreq;
      if (state == IDLE) begin
        cpol_q <= CPOL;
        cpha_q <= CPHA;
        cnt    <= '0;
        drv    <= 1'b0;
      end
      if ((state == ADDR || state == DATA) && samp && !cs_rise) cnt <= (addr_last || word_last) ? '0 : cnt + CW'(1);
      if (state == ADDR && samp && !cs_rise) a_sr <= a_nx[ADDR_WIDTH-2:0];
      if (state == DATA && samp && !cs_rise) d_sr <= d_nx[DATA_WIDTH-2:0];
      if (addr_last) begin
        addr       <= a_nx;
        addr_valid <= 1'b1;
        txreq      <= a_nx[ADDR_WIDTH-1];
      end
      if (word_last) begin
        if (!rw) rxdata <= d_nx;
        rx_valid <= !rw;
`ifdef SPI_SLAVE_BURST_EN
        addr       <= {rw, addr[ADDR_WIDTH-2:0] + (ADDR_WIDTH-1)'(1)};
        addr_valid <= 1'b1;
        txreq      <= rw;
        drv        <= 1'b0;
`endif
      end
      // The first shift edge of a read word only enables the driver (MSB already loaded); later ones shift.
      if (ld) tx_sr <= txdata;
      else if (state == DATA && shft && !cs_rise && rw) begin
        if (drv) tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
        drv <= 1'b1;
      end
    end
endmodule

// File: tb/tb_spi_slave_mode.sv
// tb_spi_slave_mode: directed self-checking bench for spi_slave_mode acting as an SPI master model.
module tb_spi_slave_mode;
  logic clk = 0, rst_n = 0, cpol = 0, cpha = 0, cs = 1, sck = 0, mosi = 0;
  logic miso, txreq, addr_valid, rx_valid, spi_over, frame_err;
  logic [15:0] txdata = 16'h0, rxdata;
  logic [7:0] addr;
  logic [63:0] rx;
  int checks = 0, errors = 0;
  int n_av = 0, n_rv = 0, n_tr = 0, n_ov = 0, n_fe = 0;
  int av0, rv0, tr0, ov0, fe0;
  logic [7:0] aq[$];
  always #5 clk = ~clk;
  spi_slave_mode #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .CPOL(cpol), .CPHA(cpha), .spi_cs(cs), .spi_sck(sck), .spi_mosi(mosi),
    .spi_miso(miso), .txdata(txdata), .txreq(txreq), .addr(addr), .addr_valid(addr_valid),
    .rxdata(rxdata), .rx_valid(rx_valid), .spi_over(spi_over), .frame_err(frame_err)
  );
  always @(negedge clk) begin
    if (addr_valid) begin
      n_av++;
      aq.push_back(addr);
    end
    if (rx_valid) n_rv++;
    if (txreq) n_tr++;
    if (spi_over) n_ov++;
    if (frame_err) n_fe++;
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic snap();
    av0 = n_av; rv0 = n_rv; tr0 = n_tr; ov0 = n_ov; fe0 = n_fe;
  endtask
  task automatic set_mode(input logic p, input logic h);
    cpol = p; cpha = h; sck = p;
    idle(6);
  endtask
  task automatic frame(input logic [63:0] tx, input int nbits, input bit rel, output logic [63:0] r);
    r = '0;
    cs = 0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = tx[63-i];
        idle(5);
        r = {r[62:0], miso};
        sck = ~cpol;
        idle(5);
        sck = cpol;
      end else begin
        sck = ~cpol;
        mosi = tx[63-i];
        idle(5);
        r = {r[62:0], miso};
        sck = cpol;
        idle(5);
      end
    end
    if (rel) begin
      idle(5);
      cs = 1;
      mosi = 0;
      idle(8);
    end
  endtask
  task automatic test_reset();
    idle(3);
    checks++; if (addr !== 8'h00) begin errors++; $display("FAIL reset addr: got %h expected 00", addr); end
    checks++; if (rxdata !== 16'h0000) begin errors++; $display("FAIL reset rxdata: got %h expected 0000", rxdata); end
    checks++; if ({miso, txreq, addr_valid, rx_valid, spi_over, frame_err} !== 6'b0) begin
      errors++; $display("FAIL reset pulses: got %b expected 000000", {miso, txreq, addr_valid, rx_valid, spi_over, frame_err});
    end
    rst_n = 1;
    idle(6);
  endtask
  task automatic test_mode0_write();
    set_mode(0, 0);
    snap();
    frame({8'h3C, 16'h1234, 40'h0}, 24, 1, rx);
    checks++; if (addr !== 8'h3C) begin errors++; $display("FAIL m0w addr: got %h expected 3c", addr); end
    checks++; if (rxdata !== 16'h1234) begin errors++; $display("FAIL m0w rxdata: got %h expected 1234", rxdata); end
    checks++; if (n_av - av0 !== 1) begin errors++; $display("FAIL m0w addr_valid count: got %0d expected 1", n_av - av0); end
    checks++; if (n_rv - rv0 !== 1) begin errors++; $display("FAIL m0w rx_valid count: got %0d expected 1", n_rv - rv0); end
    checks++; if (n_ov - ov0 !== 1) begin errors++; $display("FAIL m0w spi_over count: got %0d expected 1", n_ov - ov0); end
    checks++; if (n_tr - tr0 !== 0) begin errors++; $display("FAIL m0w txreq count: got %0d expected 0", n_tr - tr0); end
    checks++; if (rx[23:0] !== 24'h0) begin errors++; $display("FAIL m0w miso: got %h expected 000000", rx[23:0]); end
  endtask
  task automatic test_mode0_read();
    set_mode(0, 0);
    txdata = 16'h3333;
    snap();
    frame({8'hF8, 16'h0, 40'h0}, 24, 1, rx);
    checks++; if (addr !== 8'hF8) begin errors++; $display("FAIL m0r addr: got %h expected f8", addr); end
    checks++; if (n_tr - tr0 !== 1) begin errors++; $display("FAIL m0r txreq count: got %0d expected 1", n_tr - tr0); end
    checks++; if (rx[15:0] !== 16'h3333) begin errors++; $display("FAIL m0r master rxdata: got %h expected 3333", rx[15:0]); end
    checks++; if (rx[23:16] !== 8'h00) begin errors++; $display("FAIL m0r miso in addr: got %h expected 00", rx[23:16]); end
    checks++; if (n_rv - rv0 !== 0) begin errors++; $display("FAIL m0r rx_valid count: got %0d expected 0", n_rv - rv0); end
    checks++; if (n_ov - ov0 !== 1) begin errors++; $display("FAIL m0r spi_over count: got %0d expected 1", n_ov - ov0); end
  endtask
  task automatic test_modes();
    for (int m = 1; m < 4; m++) begin
      set_mode(1'(m >> 1), 1'(m & 1));
      snap();
      frame({8'h7C, 16'hEDCB, 40'h0}, 24, 1, rx);
      checks++; if (addr !== 8'h7C) begin errors++; $display("FAIL mode%0d write addr: got %h expected 7c", m, addr); end
      checks++; if (rxdata !== 16'hEDCB) begin errors++; $display("FAIL mode%0d write rxdata: got %h expected edcb", m, rxdata); end
      checks++; if (n_rv - rv0 !== 1) begin errors++; $display("FAIL mode%0d write rx_valid count: got %0d expected 1", m, n_rv - rv0); end
      checks++; if (rx[23:0] !== 24'h0) begin errors++; $display("FAIL mode%0d write miso: got %h expected 000000", m, rx[23:0]); end
      txdata = 16'h4444;
      snap();
      frame({8'h9F, 16'h0, 40'h0}, 24, 1, rx);
      checks++; if (addr !== 8'h9F) begin errors++; $display("FAIL mode%0d read addr: got %h expected 9f", m, addr); end
      checks++; if (rx[15:0] !== 16'h4444) begin errors++; $display("FAIL mode%0d read data: got %h expected 4444", m, rx[15:0]); end
      checks++; if (n_tr - tr0 !== 1) begin errors++; $display("FAIL mode%0d read txreq count: got %0d expected 1", m, n_tr - tr0); end
      checks++; if (n_rv - rv0 !== 0) begin errors++; $display("FAIL mode%0d read rx_valid count: got %0d expected 0", m, n_rv - rv0); end
      checks++; if (n_ov - ov0 !== 1) begin errors++; $display("FAIL mode%0d read spi_over count: got %0d expected 1", m, n_ov - ov0); end
    end
  endtask
  task automatic test_short_frame();
    set_mode(0, 0);
    snap();
    frame({8'h3C, 16'hFFFF, 40'h0}, 12, 1, rx);
    checks++; if (n_fe - fe0 !== 1) begin errors++; $display("FAIL short frame_err count: got %0d expected 1", n_fe - fe0); end
    checks++; if (n_rv - rv0 !== 0) begin errors++; $display("FAIL short rx_valid count: got %0d expected 0", n_rv - rv0); end
    checks++; if (n_ov - ov0 !== 0) begin errors++; $display("FAIL short spi_over count: got %0d expected 0", n_ov - ov0); end
    snap();
    frame({8'h3C, 16'hA5C3, 40'h0}, 24, 1, rx);
    checks++; if (rxdata !== 16'hA5C3) begin errors++; $display("FAIL after short rxdata: got %h expected a5c3", rxdata); end
    checks++; if (n_rv - rv0 !== 1) begin errors++; $display("FAIL after short rx_valid count: got %0d expected 1", n_rv - rv0); end
    checks++; if (n_fe - fe0 !== 0) begin errors++; $display("FAIL after short frame_err count: got %0d expected 0", n_fe - fe0); end
  endtask
  task automatic test_reset_mid_frame();
    set_mode(0, 0);
    frame({8'h55, 16'hFFFF, 40'h0}, 13, 0, rx);
    rst_n = 0;
    #1;
    checks++; if (addr !== 8'h00) begin errors++; $display("FAIL midrst addr: got %h expected 00", addr); end
    checks++; if (rxdata !== 16'h0000) begin errors++; $display("FAIL midrst rxdata: got %h expected 0000", rxdata); end
    checks++; if ({miso, txreq, addr_valid, rx_valid, spi_over, frame_err} !== 6'b0) begin
      errors++; $display("FAIL midrst pulses: got %b expected 000000", {miso, txreq, addr_valid, rx_valid, spi_over, frame_err});
    end
    cs = 1; sck = 0; mosi = 0;
    idle(4);
    rst_n = 1;
    snap();
    idle(6);
    frame({8'h3C, 16'hBEEF, 40'h0}, 24, 1, rx);
    checks++; if (addr !== 8'h3C) begin errors++; $display("FAIL after rst addr: got %h expected 3c", addr); end
    checks++; if (rxdata !== 16'hBEEF) begin errors++; $display("FAIL after rst rxdata: got %h expected beef", rxdata); end
    checks++; if (n_fe - fe0 !== 0) begin errors++; $display("FAIL after rst frame_err count: got %0d expected 0", n_fe - fe0); end
    checks++; if (n_ov - ov0 !== 1) begin errors++; $display("FAIL after rst spi_over count: got %0d expected 1", n_ov - ov0); end
  endtask
  task automatic test_burst();
    int q0;
    set_mode(0, 0);
    snap();
    q0 = aq.size();
    frame({8'h7F, 16'h1111, 16'h2222, 16'h3333, 8'h0}, 56, 1, rx);
    checks++; if (n_ov - ov0 !== 1) begin errors++; $display("FAIL burst spi_over count: got %0d expected 1", n_ov - ov0); end
    checks++; if (n_fe - fe0 !== 0) begin errors++; $display("FAIL burst frame_err count: got %0d expected 0", n_fe - fe0); end
`ifdef SPI_SLAVE_BURST_EN
    checks++; if (n_rv - rv0 !== 3) begin errors++; $display("FAIL burst rx_valid count: got %0d expected 3", n_rv - rv0); end
    checks++; if (rxdata !== 16'h3333) begin errors++; $display("FAIL burst rxdata: got %h expected 3333", rxdata); end
    checks++; if (aq.size() - q0 < 3) begin errors++; $display("FAIL burst addr_valid count: got %0d expected >=3", aq.size() - q0); end
    else begin
      checks++; if (aq[q0] !== 8'h7F) begin errors++; $display("FAIL burst addr0: got %h expected 7f", aq[q0]); end
      checks++; if (aq[q0+1] !== 8'h00) begin errors++; $display("FAIL burst addr1: got %h expected 00", aq[q0+1]); end
      checks++; if (aq[q0+2] !== 8'h01) begin errors++; $display("FAIL burst addr2: got %h expected 01", aq[q0+2]); end
    end
`else
    checks++; if (n_rv - rv0 !== 1) begin errors++; $display("FAIL single rx_valid count: got %0d expected 1", n_rv - rv0); end
    checks++; if (rxdata !== 16'h1111) begin errors++; $display("FAIL single rxdata: got %h expected 1111", rxdata); end
    checks++; if (n_av - av0 !== 1) begin errors++; $display("FAIL single addr_valid count: got %0d expected 1", n_av - av0); end
    checks++; if (aq.size() > q0 && aq[q0] !== 8'h7F) begin errors++; $display("FAIL single addr: got %h expected 7f", aq[q0]); end
`endif
  endtask
  initial begin
    test_reset();
    test_mode0_write();
    test_mode0_read();
    test_modes();
    test_short_frame();
    test_reset_mid_frame();
    test_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
